// File: rtl/babel_pkg.sv
// Shared constants and types for the falling-block datapath.
// Used by the drop controller and the vertical position register.
package babel_pkg;

   localparam int Y_INIT     = 104;
   localparam int Y_TOP      = 0;
   localparam int UNIT_BLOCK = 16;
   localparam int Y_W        = 7;
   localparam int LEVEL_W    = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FALL = 2'd1,
      LAND = 2'd2
   } state_t;

endpackage

// File: rtl/y_drop_controller_if.sv
// Request/position bundle between the drop controller and its users.
// master = controller side, slave = requester / position register side.
interface y_drop_controller_if;
   import babel_pkg::*;

   logic               drop;
   logic               clear;
   logic               load;
   logic [Y_W-1:0]     new_y_position;
   logic               landed;
   logic               busy;
   logic [LEVEL_W-1:0] stack_level;
   logic               full;

   modport master (
      input  drop, clear,
      output load, new_y_position, landed, busy, stack_level, full
   );

   modport slave (
      output drop, clear,
      input  load, new_y_position, landed, busy, stack_level, full
   );

endinterface

// File: rtl/tick_divider.sv
// Free-running tick generator; restart forces the count back to zero.
// tick is high in the last count of each period.
module tick_divider #(
   parameter int TICK_DIV = 833333
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (restart || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/y_drop_controller.sv
// Spawns a block at the top row and steps it down to the landing row
// of the current tower height, counting placed blocks.
module y_drop_controller #(
   parameter int Y_INIT     = babel_pkg::Y_INIT,
   parameter int Y_TOP      = babel_pkg::Y_TOP,
   parameter int UNIT_BLOCK = babel_pkg::UNIT_BLOCK,
   parameter int STEP       = 4,
   parameter int TICK_DIV   = 833333,
   parameter int MAX_LEVEL  = 6
) (
   input logic                 clk,
   input logic                 reset,
   y_drop_controller_if.master bus
);
   import babel_pkg::state_t, babel_pkg::IDLE;
   import babel_pkg::FALL, babel_pkg::LAND;
   import babel_pkg::Y_W, babel_pkg::LEVEL_W;

   localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(MAX_LEVEL + 1);

   if (!(Y_TOP < Y_INIT - MAX_LEVEL * UNIT_BLOCK)) begin : g_bad_geom
      $error("top row must lie above the highest landing row");
   end
   if (TICK_DIV < 1) begin : g_bad_div
      $error("TICK_DIV must be at least 1");
   end

   state_t             state, state_n;
   logic [Y_W-1:0]     y_q, y_d;
   logic [LEVEL_W-1:0] lvl_q, lvl_d;
   logic               load_q, load_d;
   logic               landed_q, landed_d;
   logic               full_q, full_d;
   logic               tick, restart;
   logic [7:0]         target, step_y, next_y;

   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   assign restart = (state == IDLE) && bus.drop
                    && !bus.clear && !full_q;

   // 8-bit math so y + STEP can exceed the row range before saturating
   assign target = full_q ? 8'(Y_INIT)
                 : 8'(Y_INIT) - 8'(lvl_q) * 8'(UNIT_BLOCK);
   assign step_y = {1'b0, y_q} + 8'(STEP);
   assign next_y = (step_y >= target) ? target : step_y;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         y_q      <= Y_W'(Y_INIT);
         lvl_q    <= '0;
         load_q   <= 1'b0;
         landed_q <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         state    <= state_n;
         y_q      <= y_d;
         lvl_q    <= lvl_d;
         load_q   <= load_d;
         landed_q <= landed_d;
         full_q   <= full_d;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (restart) state_n = FALL;
         FALL:    if (tick && next_y == target) state_n = LAND;
         LAND:    if (landed_q) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // LAND spans two cycles: the final load, then the landed pulse
   always_comb begin
      load_d   = 1'b0;
      y_d      = y_q;
      landed_d = 1'b0;
      lvl_d    = lvl_q;
      unique case (1'b1)
         (state == IDLE) && bus.clear: lvl_d = '0;
         restart: begin
            load_d = 1'b1;
            y_d    = Y_W'(Y_TOP);
         end
         (state == FALL) && tick: begin
            load_d = 1'b1;
            y_d    = next_y[Y_W-1:0];
         end
         (state == LAND) && !landed_q: landed_d = 1'b1;
         (state == LAND) && landed_q:  lvl_d = lvl_q + LEVEL_W'(1);
         default: ;
      endcase
      full_d = (lvl_d == LVL_FULL);
   end

   assign bus.load           = load_q;
   assign bus.new_y_position = y_q;
   assign bus.landed         = landed_q;
   assign bus.busy           = (state != IDLE);
   assign bus.stack_level    = lvl_q;
   assign bus.full           = full_q;

endmodule

// File: tb/tb_y_drop_controller.sv
// Directed + randomized bench for y_drop_controller with a queue-based
// fall model; dut_a uses TICK_DIV=2/STEP=4, dut_b TICK_DIV=1/STEP=5.
module tb_y_drop_controller;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   mlvl [2];
   bit   sel;
   int   landing [7];

   y_drop_controller_if bus_a ();
   y_drop_controller_if bus_b ();

   y_drop_controller #(.TICK_DIV(2), .STEP(4)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   y_drop_controller #(.TICK_DIV(1), .STEP(5)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   logic       o_load, o_landed, o_busy, o_full;
   logic [6:0] o_y;
   logic [2:0] o_lvl;

   assign o_load   = sel ? bus_b.load : bus_a.load;
   assign o_landed = sel ? bus_b.landed : bus_a.landed;
   assign o_busy   = sel ? bus_b.busy : bus_a.busy;
   assign o_full   = sel ? bus_b.full : bus_a.full;
   assign o_y      = sel ? bus_b.new_y_position : bus_a.new_y_position;
   assign o_lvl    = sel ? bus_b.stack_level : bus_a.stack_level;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_in(input bit b, input bit d, input bit cl);
      if (b) begin
         bus_b.drop  = d;
         bus_b.clear = cl;
      end else begin
         bus_a.drop  = d;
         bus_a.clear = cl;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit b, input int n);
      sel = b;
      for (int i = 0; i < n; i++) begin
         step();
         check("idle_load", o_load, 0);
         check("idle_busy", o_busy, 0);
         check("idle_level", o_lvl, mlvl[b]);
      end
   endtask

   // One drop and the complete fall, checked cycle by cycle.
   task automatic fall(input bit b, input bit noise);
      int td, stp, tgt, y, n, last, nz, cur;
      int ys[$];
      bit el;
      sel = b;
      td  = b ? 1 : 2;
      stp = b ? 5 : 4;
      tgt = 104 - 16 * mlvl[b];
      y = 0;
      ys = {};
      while (y != tgt) begin
         y = (y + stp > tgt) ? tgt : y + stp;
         ys.push_back(y);
      end
      n    = ys.size();
      last = n * td;
      nz   = noise ? int'($urandom_range(1, last - 1)) : -1;
      set_in(b, 1'b1, 1'b0);
      step();
      set_in(b, 1'b0, 1'b0);
      check("spawn_load", o_load, 1);
      check("spawn_y", o_y, 0);
      check("spawn_busy", o_busy, 1);
      cur = 0;
      for (int c = 1; c <= last + 2; c++) begin
         if (c == nz) begin
            set_in(b, 1'b1, ($urandom_range(0, 1) == 1));
         end else if (c == nz + 1) begin
            set_in(b, 1'b0, 1'b0);
         end
         step();
         el = (c % td == 0) && (c <= last);
         if (el) cur = ys[c / td - 1];
         check("fall_load", o_load, el);
         check("fall_y", o_y, cur);
         check("fall_landed", o_landed, c == last + 1);
         check("fall_busy", o_busy, c <= last + 1);
         check("fall_level", o_lvl,
               (c <= last + 1) ? mlvl[b] : mlvl[b] + 1);
      end
      check("landing_row", o_y, landing[mlvl[b]]);
      mlvl[b]++;
      check("full_flag", o_full, mlvl[b] == 7);
   endtask

   task automatic drop_when_full(input bit b);
      sel = b;
      set_in(b, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("full_drop_load", o_load, 0);
         check("full_drop_busy", o_busy, 0);
         check("full_drop_level", o_lvl, 7);
      end
      set_in(b, 1'b0, 1'b0);
   endtask

   task automatic check_reset_vals(input bit b);
      sel = b;
      #0;
      check("rst_load", o_load, 0);
      check("rst_landed", o_landed, 0);
      check("rst_busy", o_busy, 0);
      check("rst_y", o_y, 104);
      check("rst_level", o_lvl, 0);
      check("rst_full", o_full, 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      mlvl     = '{0, 0};
      sel      = 1'b0;
      landing  = '{104, 88, 72, 56, 40, 24, 8};
      reset    = 1'b1;
      set_in(0, 1'b0, 1'b0);
      set_in(1, 1'b0, 1'b0);
      repeat (3) step();
      check_reset_vals(0);
      check_reset_vals(1);
      reset = 1'b0;
      idle(0, 1);

      // first fall, then stack dut_a to full with random gaps and noise
      fall(0, 1'b0);
      for (int k = 1; k < 7; k++) begin
         idle(0, $urandom_range(0, 3));
         fall(0, ($urandom_range(0, 1) == 1));
      end
      check("a_full", o_full, 1);
      drop_when_full(0);

      set_in(0, 1'b0, 1'b1);
      step();
      set_in(0, 1'b0, 1'b0);
      mlvl[0] = 0;
      check("clear_level", o_lvl, 0);
      check("clear_full", o_full, 0);
      check("clear_load", o_load, 0);

      for (int k = 0; k < 3; k++) begin
         idle(0, $urandom_range(0, 2));
         fall(0, 1'b1);
      end
      check("level3", o_lvl, 3);
      set_in(0, 1'b1, 1'b1);
      step();
      set_in(0, 1'b0, 1'b0);
      mlvl[0] = 0;
      check("dc_load", o_load, 0);
      check("dc_busy", o_busy, 0);
      check("dc_level", o_lvl, 0);
      idle(0, 2);

      // dut_b: single-cycle ticks, step 5 saturating onto the target
      for (int k = 0; k < 7; k++) begin
         idle(1, $urandom_range(0, 2));
         fall(1, ($urandom_range(0, 1) == 1));
      end
      check("b_full", o_full, 1);
      drop_when_full(1);

      // reset mid-fall, with dut_b full
      idle(0, 1);
      fall(0, 1'b0);
      sel = 1'b0;
      set_in(0, 1'b1, 1'b0);
      step();
      set_in(0, 1'b0, 1'b0);
      repeat ($urandom_range(4, 40)) step();
      check("pre_rst_busy", o_busy, 1);
      reset = 1'b1;
      #2;
      check_reset_vals(0);
      check_reset_vals(1);
      step();
      reset = 1'b0;
      mlvl = '{0, 0};
      idle(0, 2);
      check("post_rst_y", o_y, 104);
      fall(0, 1'b0);
      check("post_rst_level", o_lvl, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
